rtc_bus_sched: RTL

- Shared-bus transaction scheduler for the external RTC's multiplexed AD bus (ad/wr/rd/cs strobes, 8-bit address/data).
- Accepts single-byte read/write requests from up to N_REQ client engines (time setter, date setter, alarm, readback) and arbitrates them round-robin.
- Runs the complete bus cycle itself and returns an ack to the client, with read data on reads.
- Clients no longer drive the bus directly; this block is the only bus master.

---
 rtl/rtc_bus_pkg.sv | 25 ++
 rtl/rtc_bus_sched_if.sv | 30 +++
 rtl/rtc_rr_arbiter.sv | 31 +++
 rtl/rtc_bus_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus scheduler: FSM states, RTC register map and strobe levels.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ALE,
    TURN,
    STROBE,
    RELEASE,
    RECOV
  } state_t;

  localparam logic [7:0] REG_HORA = 8'h21;
  localparam logic [7:0] REG_MIN  = 8'h22;
  localparam logic [7:0] REG_SEG  = 8'h23;

  localparam logic STROBE_IDLE = 1'b1;
  localparam logic STROBE_ACT  = 1'b0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_bus_sched_if.sv
// Client request/ack handshake plus the multiplexed RTC AD bus pins.
// master = the scheduler (sole bus master), slave = clients and the RTC device side.
interface rtc_bus_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_rw;
  logic [8*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         rdata;
  logic               busy;
  logic [7:0]         ad_o;
  logic               ad_oe;
  logic [7:0]         ad_i;
  logic               ad;
  logic               wr;
  logic               rd;
  logic               cs;

  modport master (
    input  req, req_rw, req_addr, req_wdata, ad_i,
    output ack, rdata, busy, ad_o, ad_oe, ad, wr, rd, cs
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, ad_i,
    input  ack, rdata, busy, ad_o, ad_oe, ad, wr, rd, cs
  );
endinterface

// File: rtl/rtc_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping cyclically.
module rtc_rr_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    grant,
  output logic             valid
);

  logic [IW:0] slot;

  // Walk from the farthest offset back to ptr so the closest set bit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    slot  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      slot = {1'b0, ptr} + (IW + 1)'(k);
      if (slot >= (IW + 1)'(N_REQ)) slot = slot - (IW + 1)'(N_REQ);
      if (req[slot[IW-1:0]]) begin
        grant = slot[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_sched.sv
// Sole master of the RTC multiplexed AD bus: round-robin over client requests, runs the full cycle, acks.
// Optional periodic time readback is built when RTC_BUS_PERIODIC_READ_EN is defined.
module rtc_bus_sched
  import rtc_bus_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int T_ADDR         = 2,
  parameter int T_STROBE       = 4,
  parameter int T_RECOV        = 4,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  rtc_bus_sched_if.master   bus,
  output logic [7:0]        rt_hora,
  output logic [7:0]        rt_min,
  output logic [7:0]        rt_seg,
  output logic              rt_valid
);

  localparam int IW = idx_width(N_REQ);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    phase;
  logic [3:0]    phase_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] arb_idx;
  logic          arb_vld;
  logic          lat_rw;
  logic          lat_int;
  logic [7:0]    lat_addr;
  logic [7:0]    lat_wdata;
  logic [7:0]    rdata_q;
  logic          start_ext;
  logic          start_int;
  logic          capture;
  logic          done;
  logic          ref_go;
  logic [7:0]    ref_addr;

  rtc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (arb_idx),
    .valid (arb_vld)
  );

  // External clients always beat the internal refresh requester.
  assign start_ext = (state == IDLE) && arb_vld;
  assign start_int = (state == IDLE) && !arb_vld && ref_go;
  assign capture   = (state == STROBE) && (phase == 4'd0) && lat_rw;
  assign done      = (state == RECOV) && (phase == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    unique case (state)
      IDLE: begin
        if (start_ext || start_int) begin
          state_nxt = ADDR;
          phase_nxt = 4'(T_ADDR - 1);
        end
      end
      ADDR: begin
        if (phase == 4'd0) begin
          state_nxt = ALE;
          phase_nxt = 4'd0;
        end else begin
          phase_nxt = phase - 4'd1;
        end
      end
      ALE: begin
        state_nxt = TURN;
        phase_nxt = 4'd0;
      end
      TURN: begin
        state_nxt = STROBE;
        phase_nxt = 4'(T_STROBE - 1);
      end
      STROBE: begin
        if (phase == 4'd0) begin
          state_nxt = RELEASE;
          phase_nxt = 4'd0;
        end else begin
          phase_nxt = phase - 4'd1;
        end
      end
      RELEASE: begin
        state_nxt = RECOV;
        phase_nxt = 4'(T_RECOV - 1);
      end
      RECOV: begin
        if (phase == 4'd0) begin
          state_nxt = IDLE;
          phase_nxt = 4'd0;
        end else begin
          phase_nxt = phase - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    bus.ad    = STROBE_IDLE;
    bus.wr    = STROBE_IDLE;
    bus.rd    = STROBE_IDLE;
    bus.cs    = STROBE_IDLE;
    bus.ad_oe = 1'b0;
    bus.ad_o  = 8'h00;
    bus.busy  = (state != IDLE);
    bus.ack   = '0;
    unique case (state)
      ADDR, ALE: begin
        bus.ad    = (state == ADDR) ? STROBE_IDLE : STROBE_ACT;
        bus.cs    = STROBE_ACT;
        bus.ad_oe = 1'b1;
        bus.ad_o  = lat_addr;
      end
      TURN, STROBE, RELEASE: begin
        bus.ad = STROBE_ACT;
        bus.cs = STROBE_ACT;
        // Reads leave the bus floating from TURN so the RTC can drive it.
        if (!lat_rw) begin
          bus.ad_oe = 1'b1;
          bus.ad_o  = lat_wdata;
        end
        if (state == STROBE) begin
          if (lat_rw) bus.rd = STROBE_ACT;
          else        bus.wr = STROBE_ACT;
        end
      end
      RECOV: begin
        if (done && !lat_int) bus.ack[gnt] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= 4'd0;
      ptr       <= '0;
      gnt       <= '0;
      lat_rw    <= 1'b0;
      lat_int   <= 1'b0;
      lat_addr  <= 8'h00;
      lat_wdata <= 8'h00;
      rdata_q   <= 8'h00;
    end else begin
      phase <= phase_nxt;
      if (start_ext) begin
        gnt       <= arb_idx;
        lat_int   <= 1'b0;
        lat_rw    <= bus.req_rw[arb_idx];
        lat_addr  <= bus.req_addr[8*int'(arb_idx) +: 8];
        lat_wdata <= bus.req_wdata[8*int'(arb_idx) +: 8];
      end else if (start_int) begin
        lat_int   <= 1'b1;
        lat_rw    <= 1'b1;
        lat_addr  <= ref_addr;
        lat_wdata <= 8'h00;
      end
      if (capture && !lat_int) rdata_q <= bus.ad_i;
      if (done && !lat_int) begin
        ptr <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  assign bus.rdata = rdata_q;

`ifdef RTC_BUS_PERIODIC_READ_EN
  localparam int TW = $clog2(REFRESH_CYCLES + 1);

  logic [TW-1:0] tmr;
  logic          pend;
  logic [1:0]    seq;

  assign ref_go   = pend;
  assign ref_addr = (seq == 2'd0) ? REG_HORA : (seq == 2'd1) ? REG_MIN : REG_SEG;
  assign rt_valid = done && lat_int && (seq == 2'd2);

  // An expiry coinciding with the final completion lands while still pending and is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmr     <= '0;
      pend    <= 1'b0;
      seq     <= 2'd0;
      rt_hora <= 8'h00;
      rt_min  <= 8'h00;
      rt_seg  <= 8'h00;
    end else begin
      if (tmr == TW'(REFRESH_CYCLES - 1)) begin
        tmr  <= '0;
        pend <= 1'b1;
      end else begin
        tmr <= tmr + 1'b1;
      end
      if (capture && lat_int) begin
        unique case (seq)
          2'd0:    rt_hora <= bus.ad_i;
          2'd1:    rt_min  <= bus.ad_i;
          default: rt_seg  <= bus.ad_i;
        endcase
      end
      if (done && lat_int) begin
        if (seq == 2'd2) begin
          seq  <= 2'd0;
          pend <= 1'b0;
        end else begin
          seq <= seq + 2'd1;
        end
      end
    end
  end
`else
  assign ref_go   = 1'b0;
  assign ref_addr = 8'h00;
  assign rt_hora  = 8'h00;
  assign rt_min   = 8'h00;
  assign rt_seg   = 8'h00;
  assign rt_valid = 1'b0;
`endif

endmodule
